// File: rtl/boot_pkg.sv
// -----------------------------------------------------------------------------
// boot_pkg
// Shared types and widths for the boot sequencer slice.
//   WORD_W  instruction word width
//   ADDR_W  instruction ROM address width (also the cpu16 pc width)
//   RUN_W   width of the CPU run-cycle counter
//   state_t sequencer states; CHECK exists only with BOOT_CHECKSUM_EN defined
// -----------------------------------------------------------------------------
package boot_pkg;

  localparam int WORD_W = 16;
  localparam int ADDR_W = 15;
  localparam int RUN_W  = 24;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
`ifdef BOOT_CHECKSUM_EN
    CHECK = 3'd2,
`endif
    RUN   = 3'd3,
    DONE  = 3'd4,
    ERROR = 3'd5
  } state_t;

endpackage

// File: rtl/boot_sequencer_if.sv
// -----------------------------------------------------------------------------
// boot_sequencer_if
// Groups the host load stream, ROM write port, cpu16 control and status.
//   master : host / CPU side (drives start, ld_*, cpu_pc)
//   slave  : boot_sequencer side (drives ld_ready, rom_*, cpu_reset, status)
// -----------------------------------------------------------------------------
interface boot_sequencer_if;
  import boot_pkg::*;

  logic              start;
  logic              ld_valid;
  logic [WORD_W-1:0] ld_data;
  logic              ld_last;
  logic              ld_ready;
  logic              rom_we;
  logic [ADDR_W-1:0] rom_addr;
  logic [WORD_W-1:0] rom_wdata;
  logic              cpu_reset;
  logic [ADDR_W-1:0] cpu_pc;
  logic              busy;
  logic              done;
  logic              error;
  logic [RUN_W-1:0]  run_cycles;

  modport master (
    output start, ld_valid, ld_data, ld_last, cpu_pc,
    input  ld_ready, rom_we, rom_addr, rom_wdata, cpu_reset,
           busy, done, error, run_cycles
  );

  modport slave (
    input  start, ld_valid, ld_data, ld_last, cpu_pc,
    output ld_ready, rom_we, rom_addr, rom_wdata, cpu_reset,
           busy, done, error, run_cycles
  );

endinterface

// File: rtl/boot_sequencer_halt_detect.sv
// -----------------------------------------------------------------------------
// halt_detect
// Flags a halted cpu16: the pc equals its value from two cycles earlier for
// HALT_REPEAT consecutive cycles. Comparing against the pc two cycles back
// catches both a jump-to-self and a two-instruction jump loop.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   i_en       : CPU running; low clears the pc history and repeat counter
//   i_pc       : cpu16 program counter
//   halted     : combinational, high on the cycle the repeat count is reached
// -----------------------------------------------------------------------------
module halt_detect
  import boot_pkg::*;
#(
  parameter int HALT_REPEAT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_en,
  input  logic [ADDR_W-1:0] i_pc,
  output logic              halted
);

  localparam int REP_W = (HALT_REPEAT > 1) ? $clog2(HALT_REPEAT) : 1;
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(HALT_REPEAT - 1);

  logic [ADDR_W-1:0] r_pc_d1;
  logic [ADDR_W-1:0] r_pc_d2;
  logic [1:0]        r_fill;
  logic [REP_W-1:0]  r_rep;
  logic              w_match;

  // history must hold two real samples before a compare means anything
  assign w_match = (r_fill == 2'd2) && (i_pc == r_pc_d2);
  assign halted  = w_match && (r_rep == REP_LAST);

  always_ff @(posedge clk) begin
    if (reset || !i_en) begin
      r_pc_d1 <= '0;
      r_pc_d2 <= '0;
      r_fill  <= '0;
      r_rep   <= '0;
    end else begin
      r_pc_d1 <= i_pc;
      r_pc_d2 <= r_pc_d1;
      if (r_fill != 2'd2) r_fill <= r_fill + 2'd1;
      if (!w_match)
        r_rep <= '0;
      else if (r_rep != REP_LAST)
        r_rep <= r_rep + 1'b1;
    end
  end

endmodule

// File: rtl/boot_sequencer.sv
// -----------------------------------------------------------------------------
// boot_sequencer
// Loads a host instruction stream into the cpu16 ROM, releases the CPU from
// reset, counts run cycles and stops the CPU once it parks in a jump loop.
// Optional macro BOOT_CHECKSUM_EN: the ld_last word is a mod-2^16 checksum of
// the preceding words, checked in CHECK instead of being written.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   bus        : boot_sequencer_if.slave (load stream, ROM write, CPU, status)
// Parameters:
//   MAX_WORDS   : words that may be written (1..32768)
//   HALT_REPEAT : consecutive halt-pattern cycles that declare a halt
//
// state | meaning
// IDLE  | after reset, CPU held in reset, waiting for start
// LOAD  | accepting host words, writing ROM
// CHECK | compare received checksum against running sum (macro only)
// RUN   | CPU released (one cycle after entry), counting run cycles
// DONE  | CPU halted and held in reset, run_cycles frozen
// ERROR | overflow or checksum mismatch, CPU held in reset
// -----------------------------------------------------------------------------
module boot_sequencer
  import boot_pkg::*;
#(
  parameter int MAX_WORDS   = 32768,
  parameter int HALT_REPEAT = 4
) (
  input  logic            clk,
  input  logic            reset,
  boot_sequencer_if.slave bus
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WORDS);

  state_t            r_state;
  logic              r_ld_ready;
  logic              r_rom_we;
  logic [ADDR_W-1:0] r_rom_addr;
  logic [WORD_W-1:0] r_rom_wdata;
  logic              r_cpu_reset;
  logic              r_busy;
  logic              r_done;
  logic              r_error;
  logic [RUN_W-1:0]  r_run_cycles;
  logic [CNT_W-1:0]  r_cnt;
`ifdef BOOT_CHECKSUM_EN
  logic [WORD_W-1:0] r_sum;
  logic [WORD_W-1:0] r_check_word;
`endif

  logic w_accept;
  logic w_full;
  logic w_run_sat;
  logic w_hd_en;
  logic w_halted;

  assign w_accept  = bus.ld_valid && r_ld_ready;
  assign w_full    = (r_cnt == CNT_MAX);
  assign w_run_sat = &r_run_cycles;
  assign w_hd_en   = (r_state == RUN) && !r_cpu_reset;

  halt_detect #(
    .HALT_REPEAT (HALT_REPEAT)
  ) u_halt_detect (
    .clk    (clk),
    .reset  (reset),
    .i_en   (w_hd_en),
    .i_pc   (bus.cpu_pc),
    .halted (w_halted)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_ld_ready   <= 1'b0;
      r_rom_we     <= 1'b0;
      r_rom_addr   <= '0;
      r_rom_wdata  <= '0;
      r_cpu_reset  <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_run_cycles <= '0;
      r_cnt        <= '0;
`ifdef BOOT_CHECKSUM_EN
      r_sum        <= '0;
      r_check_word <= '0;
`endif
    end else begin
      r_rom_we <= 1'b0;

      // cpu_reset is low only in RUN, so this covers exactly the run cycles
      if (!r_cpu_reset && !w_run_sat)
        r_run_cycles <= r_run_cycles + 1'b1;

      case (r_state)
        IDLE, DONE, ERROR: begin
          if (bus.start) begin
            r_state      <= LOAD;
            r_ld_ready   <= 1'b1;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_cnt        <= '0;
            r_run_cycles <= '0;
`ifdef BOOT_CHECKSUM_EN
            r_sum        <= '0;
`endif
          end
        end

        LOAD: begin
          if (w_accept) begin
            if (w_full) begin
              r_state    <= ERROR;
              r_ld_ready <= 1'b0;
              r_busy     <= 1'b0;
              r_error    <= 1'b1;
            end
`ifdef BOOT_CHECKSUM_EN
            else if (bus.ld_last) begin
              r_check_word <= bus.ld_data;
              r_state      <= CHECK;
              r_ld_ready   <= 1'b0;
            end
`endif
            else begin
              r_rom_we    <= 1'b1;
              r_rom_addr  <= r_cnt[ADDR_W-1:0];
              r_rom_wdata <= bus.ld_data;
              r_cnt       <= r_cnt + 1'b1;
`ifdef BOOT_CHECKSUM_EN
              r_sum       <= r_sum + bus.ld_data;
`endif
              if (bus.ld_last) begin
                r_state    <= RUN;
                r_ld_ready <= 1'b0;
              end
            end
          end
        end

`ifdef BOOT_CHECKSUM_EN
        CHECK: begin
          if (r_sum == r_check_word) begin
            r_state <= RUN;
          end else begin
            r_state <= ERROR;
            r_busy  <= 1'b0;
            r_error <= 1'b1;
          end
        end
`endif

        RUN: begin
          // entry cycle still has cpu_reset high, so the CPU sees the final
          // ROM write before it starts fetching
          r_cpu_reset <= 1'b0;
          if (w_halted) begin
            r_state     <= DONE;
            r_cpu_reset <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
          end
        end

        default: begin
          r_state     <= IDLE;
          r_ld_ready  <= 1'b0;
          r_cpu_reset <= 1'b1;
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
          r_error     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ld_ready   = r_ld_ready;
  assign bus.rom_we     = r_rom_we;
  assign bus.rom_addr   = r_rom_addr;
  assign bus.rom_wdata  = r_rom_wdata;
  assign bus.cpu_reset  = r_cpu_reset;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.error      = r_error;
  assign bus.run_cycles = r_run_cycles;

endmodule

// File: doc/boot_sequencer.md
BOOT_SEQUENCER -- requirements
Module: boot_sequencer

Interface
REQ-001 SHALL have parameter MAX_WORDS, default 32768, meaning the number of instruction words the block may load (1..32768).
REQ-002 SHALL have parameter HALT_REPEAT, default 4, meaning the consecutive halt-pattern cycles needed to declare the CPU halted (>=1).
REQ-003 SHALL have port clk  input  1  the single system clock, rising edge.
REQ-004 SHALL have port reset  input  1  the reset, which is synchronous and active-high.
REQ-005 SHALL have port start  input  1  a pulse that begins a load.
REQ-006 SHALL have port ld_valid  input  1  meaning the host word is valid.
REQ-007 SHALL have port ld_data  input  16  the host instruction word.
REQ-008 SHALL have port ld_last  input  1  which marks the final word of the stream.
REQ-009 SHALL have port ld_ready  output  1  meaning the block accepts a word.
REQ-010 SHALL have port rom_we  output  1  the instruction ROM write enable.
REQ-011 SHALL have port rom_addr  output  15  the ROM write address.
REQ-012 SHALL have port rom_wdata  output  16  the ROM write data.
REQ-013 SHALL have port cpu_reset  output  1  which drives the cpu16 reset pin.
REQ-014 SHALL have port cpu_pc  input  15  which carries the cpu16 pc.
REQ-015 SHALL have ports busy, done and error  output  1 each, meaning status.
REQ-016 SHALL have port run_cycles  output  24  the count of CPU run cycles.

Function
REQ-017 SHALL implement states IDLE, LOAD, CHECK (CHECK only exists when the macro is defined), RUN, DONE and ERROR.
REQ-018 In IDLE: ld_ready=0 and cpu_reset=1; start=1 moves to LOAD and clears the word counter, the checksum and run_cycles.
REQ-019 In LOAD: ld_ready=1; a word is accepted on a cycle where ld_valid and ld_ready are both 1.
REQ-020 An accepted word SHALL appear registered on the next cycle: rom_we=1, rom_addr = word counter, rom_wdata = ld_data; the counter then increments.
REQ-021 Accepting a word while the counter equals MAX_WORDS SHALL move to ERROR and SHALL leave rom_we low.
REQ-022 An accepted word with ld_last=1 SHALL be written normally, then move to RUN (or CHECK when the macro is defined).
REQ-023 In RUN: cpu_reset is registered low starting one cycle after the RUN entry cycle, so it is released only after the final ROM write.
REQ-024 run_cycles SHALL increment on every cycle where cpu_reset=0 and SHALL saturate at 24'hFFFFFF.
REQ-025 Halt detect: when cpu_pc equals its value from two cycles earlier for HALT_REPEAT consecutive cycles, the block moves to DONE; this covers both the 1-instruction and the 2-instruction jump loop.
REQ-026 In DONE and ERROR: cpu_reset=1, and run_cycles holds its value.
REQ-027 start=1 in DONE or ERROR SHALL restart the sequence as in REQ-018; start in LOAD or RUN is ignored.
REQ-028 busy SHALL be 1 in LOAD, CHECK and RUN; done SHALL be 1 only in DONE; error SHALL be 1 only in ERROR.
REQ-029 When start and ld_valid are high in the same IDLE cycle, the word SHALL NOT be accepted.

Reset
REQ-030 On reset=1 at a rising edge, the block SHALL go to IDLE from any state; cpu_reset=1, ld_ready=0, rom_we=0, rom_addr=0, rom_wdata=0, busy=done=error=0, run_cycles=0, and the counters and halt history are cleared.
REQ-031 A reset during LOAD SHALL abandon the stream, and no further ROM writes occur.

Configuration
REQ-032 Macro BOOT_CHECKSUM_EN: when defined, the ld_last word is the checksum and is not written to ROM; CHECK compares it against the mod-2^16 sum of the preceding words for one cycle, going to RUN on a match and to ERROR on a mismatch.
REQ-033 Without BOOT_CHECKSUM_EN, no CHECK state or sum register exists, and the ld_last word is ordinary program data.

Structure
REQ-034 The shared package boot_pkg SHALL hold the state enum typedef, the word width 16, the address width 15 and the run-counter width 24.
REQ-035 A single sub-module, halt_detect, SHALL hold the two-deep pc history and the repeat counter, with output halted.

Verification
REQ-036 Load 3 words 16'h0064, 16'hE308, 16'hE302 (last) -> rom_we on 3 consecutive cycles at addr 0,1,2; cpu_reset goes low 2 cycles after the last accept.
REQ-037 In RUN, hold cpu_pc at 15'd5 with HALT_REPEAT=4 -> done=1 within 6 cycles and cpu_reset=1; run_cycles is frozen.
REQ-038 Set MAX_WORDS=2 and send 3 words -> error=1 after the 3rd accept, and there is no 3rd rom_we.
REQ-039 With BOOT_CHECKSUM_EN, send 16'h0001, 16'h0002, then checksum 16'h0003 -> RUN; a checksum of 16'h0004 -> error=1.
REQ-040 Assert reset mid-LOAD after 1 word -> IDLE next cycle with all outputs at reset values; start then reloads from addr 0.
